// File: rtl/mem_stage_hs_if.sv
// Data-bus handshake between the MEM stage (master) and memory (slave).
// req/gnt accepts a request; rvalid/rdata returns load data later.
interface mem_stage_hs_if #(
    parameter int XLEN = 32
);
    localparam int BE_W = XLEN / 8;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: issues loads/stores over a req/gnt/rvalid bus,
// checks alignment, stalls EX while busy and registers the WB fields.
module mem_stage_hs #(
    parameter  int XLEN = 32,
    parameter  int REGW = 5,
    localparam int BE_W = XLEN / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc4,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_wdata,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [REGW-1:0]  ex_regd,
    input  logic             ex_wreg,
    input  logic             ex_wmem,
    input  logic             ex_rmem,
    input  logic [1:0]       ex_wbsel,
    input  logic [1:0]       ex_memsz,
    input  logic             ex_unsigned,
    output logic             mem_stall,
    mem_stage_hs_if.master   dbus,
    output logic             mem_valid,
    output logic [XLEN-1:0]  mem_rmemdata,
    output logic [XLEN-1:0]  mem_pc4,
    output logic [REGW-1:0]  mem_regd,
    output logic [1:0]       mem_wbsel,
    output logic             mem_wreg,
    output logic [XLEN-1:0]  mem_imm,
    output logic [XLEN-1:0]  mem_alu_result,
    output logic             mem_rmem,
    output logic             mem_wmem,
    output logic             mem_misalign
);
    localparam int OFFW = $clog2(BE_W);

    typedef enum logic {IDLE, WAIT_R} state_t;

    state_t            state, nxt;
    logic              mis, is_mem, go, req, stall;
    logic [OFFW-1:0]   lane;
    logic [BE_W-1:0]   sz_mask;
    logic [XLEN-1:0]   amask, wrep, rsh, ld_data;

    assign is_mem = ex_valid & (ex_rmem | ex_wmem);
    assign go     = is_mem & ~mis;
    assign lane   = ex_alu_result[OFFW-1:0];
    assign rsh    = dbus.rdata >> {lane, 3'b000};

    // Size decode: alignment check, lane mask, address mask and store replication.
    always_comb begin
        mis     = 1'b0;
        sz_mask = '1;
        amask   = '1;
        wrep    = ex_wdata;
        case (ex_memsz)
            2'b00: begin
                sz_mask = BE_W'(1);
                wrep    = {BE_W{ex_wdata[7:0]}};
            end
            2'b01: begin
                mis     = ex_alu_result[0];
                sz_mask = BE_W'(3);
                amask   = ~XLEN'(1);
                wrep    = {(XLEN/16){ex_wdata[15:0]}};
            end
            2'b10: begin
                mis     = |ex_alu_result[1:0];
                sz_mask = BE_W'(15);
                amask   = ~XLEN'(3);
                wrep    = {(XLEN/32){ex_wdata[31:0]}};
            end
            default: begin
                mis   = (XLEN == 32) ? 1'b1 : |ex_alu_result[2:0];
                amask = ~XLEN'(7);
            end
        endcase
    end

    // Load data: addressed lane already shifted down, then extended.
    always_comb begin
        ld_data = rsh;
        case (ex_memsz)
            2'b00:
                if (ex_unsigned) ld_data = XLEN'(rsh[7:0]);
                else             ld_data = XLEN'($signed(rsh[7:0]));
            2'b01:
                if (ex_unsigned) ld_data = XLEN'(rsh[15:0]);
                else             ld_data = XLEN'($signed(rsh[15:0]));
            2'b10:
                if (ex_unsigned) ld_data = XLEN'(rsh[31:0]);
                else             ld_data = XLEN'($signed(rsh[31:0]));
            default: ld_data = rsh;
        endcase
    end

    always_comb begin
        nxt   = state;
        req   = 1'b0;
        stall = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    req = 1'b1;
                    if (dbus.gnt) begin
                        // Stores retire on grant; loads wait for rvalid.
                        stall = ~ex_wmem;
                        if (!ex_wmem) nxt = WAIT_R;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                stall = ~dbus.rvalid;
                if (dbus.rvalid) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (!rst_n) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    assign mem_stall  = stall;
    assign dbus.req   = req;
    assign dbus.we    = ex_wmem;
    assign dbus.addr  = ex_alu_result & amask;
    assign dbus.be    = sz_mask << lane;
    assign dbus.wdata = wrep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_valid      <= 1'b0;
            mem_rmemdata   <= '0;
            mem_pc4        <= '0;
            mem_regd       <= '0;
            mem_wbsel      <= '0;
            mem_wreg       <= 1'b0;
            mem_imm        <= '0;
            mem_alu_result <= '0;
            mem_rmem       <= 1'b0;
            mem_wmem       <= 1'b0;
            mem_misalign   <= 1'b0;
        end else begin
            state <= nxt;
            if (stall) begin
                mem_valid    <= 1'b0;
                mem_wreg     <= 1'b0;
                mem_rmem     <= 1'b0;
                mem_wmem     <= 1'b0;
                mem_misalign <= 1'b0;
                mem_rmemdata <= '0;
            end else begin
                mem_valid      <= ex_valid;
                mem_pc4        <= ex_pc4;
                mem_regd       <= ex_regd;
                mem_wbsel      <= ex_wbsel;
                mem_imm        <= ex_imm;
                mem_alu_result <= ex_alu_result;
                mem_wreg       <= ex_valid & ex_wreg & ~(is_mem & mis);
                mem_wmem       <= ex_valid & ex_wmem & ~mis;
                mem_rmem       <= ex_valid & ex_rmem;
                mem_misalign   <= is_mem & mis;
                mem_rmemdata   <= (state == WAIT_R) ? ld_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: vector table of single accesses plus
// hand-written reset, stalled-store and stalled-load sequences.
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_wreg, ex_wmem, ex_rmem, ex_unsigned;
    logic [31:0] ex_pc4, ex_alu_result, ex_wdata, ex_imm;
    logic [4:0]  ex_regd;
    logic [1:0]  ex_wbsel, ex_memsz;
    logic        mem_stall, mem_valid, mem_wreg, mem_rmem, mem_wmem, mem_misalign;
    logic [31:0] mem_rmemdata, mem_pc4, mem_imm, mem_alu_result;
    logic [4:0]  mem_regd;
    logic [1:0]  mem_wbsel;
    int          total = 0;
    int          bad = 0;

    mem_stage_hs_if #(.XLEN(32)) bus ();

    mem_stage_hs #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_alu_result(ex_alu_result),
        .ex_wdata(ex_wdata), .ex_imm(ex_imm), .ex_regd(ex_regd),
        .ex_wreg(ex_wreg), .ex_wmem(ex_wmem), .ex_rmem(ex_rmem),
        .ex_wbsel(ex_wbsel), .ex_memsz(ex_memsz), .ex_unsigned(ex_unsigned),
        .mem_stall(mem_stall), .dbus(bus),
        .mem_valid(mem_valid), .mem_rmemdata(mem_rmemdata), .mem_pc4(mem_pc4),
        .mem_regd(mem_regd), .mem_wbsel(mem_wbsel), .mem_wreg(mem_wreg),
        .mem_imm(mem_imm), .mem_alu_result(mem_alu_result),
        .mem_rmem(mem_rmem), .mem_wmem(mem_wmem), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rmem, wmem, uns, wreg;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_mis, exp_wreg, exp_wmem;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [1:0] sz,
                         input logic u, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        ex_valid = v; ex_rmem = r; ex_wmem = w; ex_memsz = sz; ex_unsigned = u;
        ex_wreg = wr; ex_alu_result = a; ex_wdata = wd;
    endtask

    task automatic idle_ex();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
    endtask

    initial begin
        //           v  r  w  u wr sz     addr          wdata         rdata         req be       exp_wdata     mis wr wm data
        tv[0]  = '{1, 1, 0, 0, 1, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 0, 1, 0, 32'hDEADBEEF};
        tv[1]  = '{1, 1, 0, 0, 1, 2'b00, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 0, 1, 0, 32'hFFFFFF80};
        tv[2]  = '{1, 1, 0, 1, 1, 2'b00, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 0, 1, 0, 32'h00000080};
        tv[3]  = '{1, 1, 0, 0, 1, 2'b01, 32'h102, 32'h0, 32'h80011234, 1, 4'b1100, 32'h0, 0, 1, 0, 32'hFFFF8001};
        tv[4]  = '{1, 1, 0, 1, 1, 2'b01, 32'h100, 32'h0, 32'h8001F234, 1, 4'b0011, 32'h0, 0, 1, 0, 32'h0000F234};
        tv[5]  = '{1, 1, 0, 0, 1, 2'b00, 32'h101, 32'h0, 32'h00007F00, 1, 4'b0010, 32'h0, 0, 1, 0, 32'h0000007F};
        tv[6]  = '{1, 0, 1, 0, 0, 2'b00, 32'h101, 32'hA5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 0, 0, 1, 32'h0};
        tv[7]  = '{1, 0, 1, 0, 0, 2'b10, 32'h104, 32'h12345678, 32'hCAFEF00D, 1, 4'b1111, 32'h12345678, 0, 0, 1, 32'h0};
        tv[8]  = '{1, 1, 0, 0, 1, 2'b10, 32'h101, 32'h0, 32'h0, 0, 4'b0, 32'h0, 1, 0, 0, 32'h0};
        tv[9]  = '{1, 0, 1, 0, 0, 2'b01, 32'h103, 32'h1111, 32'h0, 0, 4'b0, 32'h0, 1, 0, 0, 32'h0};
        tv[10] = '{1, 1, 0, 0, 1, 2'b11, 32'h100, 32'h0, 32'h0, 0, 4'b0, 32'h0, 1, 0, 0, 32'h0};
        tv[11] = '{1, 0, 0, 0, 1, 2'b00, 32'h5, 32'h0, 32'h55AA55AA, 0, 4'b0, 32'h0, 0, 1, 0, 32'h0};
        tv[12] = '{0, 1, 0, 0, 1, 2'b10, 32'h100, 32'h0, 32'h0, 0, 4'b0, 32'h0, 0, 0, 0, 32'h0};

        ex_pc4 = 32'h404; ex_imm = 32'h10; ex_regd = 5'd7; ex_wbsel = 2'b01;
        bus.rdata = 32'h0;
        // A valid aligned load sits on EX during reset: no request may appear.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h100, 32'h0);
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_pc4", mem_pc4, 0);
        chk("rst_regd", mem_regd, 0);
        idle_ex();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            vec_t v;
            v = tv[i];
            drive(v.valid, v.rmem, v.wmem, v.sz, v.uns, v.wreg, v.addr, v.wdata);
            bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = ~v.rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), bus.req, v.exp_req);
            chk($sformatf("v%0d_stall", i), mem_stall, v.exp_req & ~v.wmem);
            if (v.exp_req) begin
                chk($sformatf("v%0d_be", i), bus.be, v.exp_be);
                chk($sformatf("v%0d_we", i), bus.we, v.wmem);
                if (v.wmem) chk($sformatf("v%0d_wdata", i), bus.wdata, v.exp_wdata);
            end
            @(posedge clk); #1;
            if (v.exp_req && !v.wmem) begin
                chk($sformatf("v%0d_bubble", i), mem_valid, 0);
                bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = v.rdata;
                @(negedge clk);
                chk($sformatf("v%0d_rv_stall", i), mem_stall, 0);
                chk($sformatf("v%0d_rv_req", i), bus.req, 0);
                @(posedge clk); #1;
            end
            chk($sformatf("v%0d_valid", i), mem_valid, v.valid);
            chk($sformatf("v%0d_wreg", i), mem_wreg, v.exp_wreg);
            chk($sformatf("v%0d_wmem", i), mem_wmem, v.exp_wmem);
            chk($sformatf("v%0d_mis", i), mem_misalign, v.exp_mis);
            chk($sformatf("v%0d_data", i), mem_rmemdata, v.exp_data);
            chk($sformatf("v%0d_alu", i), mem_alu_result, v.addr);
            idle_ex();
        end

        // Reset while waiting for read data; a late rvalid must be dropped.
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h100, 32'h0);
        bus.gnt = 1'b1;
        @(posedge clk); #1;
        bus.gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", mem_stall, 0);
        chk("mid_rst_req", bus.req, 0);
        chk("mid_rst_alu", mem_alu_result, 0);
        idle_ex();
        @(negedge clk);
        rst_n = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("late_rv_valid", mem_valid, 0);
        chk("late_rv_data", mem_rmemdata, 0);
        chk("late_rv_wreg", mem_wreg, 0);
        bus.rvalid = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h100, 32'h0);
        @(negedge clk);
        chk("post_rst_idle_req", bus.req, 1);
        @(posedge clk); #1;
        idle_ex();
        @(posedge clk); #1;

        // Half store held off by three cycles without grant.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h102, 32'h0000ABCD);
        for (int c = 0; c < 4; c++) begin
            bus.gnt = (c == 3);
            @(negedge clk);
            chk($sformatf("sh%0d_req", c), bus.req, 1);
            chk($sformatf("sh%0d_be", c), bus.be, 4'b1100);
            chk($sformatf("sh%0d_wd", c), bus.wdata[31:16], 16'hABCD);
            chk($sformatf("sh%0d_addr", c), bus.addr, 32'h102);
            chk($sformatf("sh%0d_stall", c), mem_stall, c < 3);
            @(posedge clk); #1;
            chk($sformatf("sh%0d_valid", c), mem_valid, c == 3);
        end
        chk("sh_wmem", mem_wmem, 1);
        idle_ex();
        @(posedge clk); #1;
        chk("sh_one_pulse", mem_valid, 0);

        // ADD passes straight through, then a load with grant and data delays.
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h5, 32'h0);
        @(negedge clk);
        chk("add_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("add_valid", mem_valid, 1);
        chk("add_alu", mem_alu_result, 32'h5);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h108, 32'h0);
        for (int c = 0; c < 4; c++) begin
            bus.gnt = (c == 2);
            @(negedge clk);
            chk($sformatf("ld%0d_stall", c), mem_stall, 1);
            chk($sformatf("ld%0d_req", c), bus.req, c < 3);
            @(posedge clk); #1;
            chk($sformatf("ld%0d_bubble", c), mem_valid, 0);
        end
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("ld_rv_stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("ld_valid", mem_valid, 1);
        chk("ld_data", mem_rmemdata, 32'h0BADF00D);
        chk("ld_wreg", mem_wreg, 1);
        idle_ex();
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
